// File: rtl/jts16_lyrmix_pkg.sv
// Shared types and constants for the tile/object layer mixer.
// JTS16_LYRMIX_HILITE_EN enables the highlight object palette.
package jts16_lyrmix_pkg;

  localparam logic [5:0] SHADOW_PAL = 6'h3F;
  localparam logic [5:0] HILITE_PAL = 6'h3E;
  localparam int         PAL_MAXW   = 16;

  // Object-priority thresholds after reset, two bits per layer, layer 0 lowest.
  localparam logic [7:0] THR_DEFAULT = {2'd1, 2'd1, 2'd2, 2'd3};

  typedef struct packed {
    logic                shadow;
    logic                hilite;
    logic                obj;
    logic [PAL_MAXW-1:0] pal;
  } cand_t;

  function automatic logic [1:0] thr_default(input int k);
    return THR_DEFAULT[k*2 +: 2];
  endfunction

  // Objects carry a 4-bit colour, tiles a 3-bit one.
  function automatic logic cand_opaque(input cand_t c);
    return c.obj ? (c.pal[3:0] != 4'd0) : (c.pal[2:0] != 3'd0);
  endfunction

endpackage

// File: rtl/jts16_lyrmix_if.sv
// Pixel/config bundle between a video source and the layer mixer.
// The hilite signal exists only with JTS16_LYRMIX_HILITE_EN.
interface jts16_lyrmix_if #(
  parameter int LAYERS = 3,
  parameter int TW     = 11,
  parameter int PALW   = 11
);
  logic                 pxl_cen;
  logic [LAYERS*TW-1:0] tile_pxl;
  logic [11:0]          obj_pxl;
  logic                 fix_top;
  logic [LAYERS:0]      gfx_en;
  logic                 cfg_we;
  logic [1:0]           cfg_addr;
  logic [1:0]           cfg_din;
  logic [PALW-1:0]      pal_addr;
  logic                 shadow;
  logic [LAYERS:0]      sel;
`ifdef JTS16_LYRMIX_HILITE_EN
  logic                 hilite;
`endif

  modport master (
    output pxl_cen, tile_pxl, obj_pxl, fix_top, gfx_en, cfg_we, cfg_addr, cfg_din,
`ifdef JTS16_LYRMIX_HILITE_EN
    input  hilite,
`endif
    input  pal_addr, shadow, sel
  );

  modport slave (
    input  pxl_cen, tile_pxl, obj_pxl, fix_top, gfx_en, cfg_we, cfg_addr, cfg_din,
`ifdef JTS16_LYRMIX_HILITE_EN
    output hilite,
`endif
    output pal_addr, shadow, sel
  );
endinterface

// File: rtl/jts16_lyrmix_cand.sv
// One layer slot of the mixer's first stage: decides object vs tile there.
// With JTS16_LYRMIX_HILITE_EN, palette HILITE_PAL marks a highlight object.
module jts16_lyrmix_cand
  import jts16_lyrmix_pkg::*;
#(
  parameter int TW       = 11,
  parameter int PALW     = 11,
  parameter bit BACKDROP = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen_i,
  input  logic [TW-1:0] tile_i,
  input  logic [11:0]   obj_i,
  input  logic [1:0]    thr_i,
  input  logic          elig_en_i,
  output cand_t         cand_o
);

  logic            eligible;
  logic            obj_wins;
  logic            is_shadow;
  logic            is_hilite;
  logic [PALW-1:0] obj_addr;
  cand_t           cand_d;
  cand_t           cand_q;

  // The backdrop slot ignores thresholds and tile priority.
  always_comb begin
    eligible  = (obj_i[3:0] != 4'd0) &&
                (BACKDROP || (elig_en_i && (obj_i[11:10] >= thr_i)));
    obj_wins  = eligible && (BACKDROP || !tile_i[TW-1] || (tile_i[2:0] == 3'd0));
    is_shadow = (obj_i[9:4] == SHADOW_PAL);
`ifdef JTS16_LYRMIX_HILITE_EN
    is_hilite = (obj_i[9:4] == HILITE_PAL);
`else
    is_hilite = 1'b0;
`endif
    obj_addr         = '0;
    obj_addr[PALW-1] = 1'b1;
    obj_addr[9:0]    = obj_i[9:0];
    cand_d     = '0;
    cand_d.pal = PAL_MAXW'(tile_i[TW-2:0]);
    if (obj_wins && is_shadow) begin
      cand_d.shadow = 1'b1;
    end else if (obj_wins && is_hilite) begin
      cand_d.hilite = 1'b1;
    end else if (obj_wins) begin
      cand_d.obj = 1'b1;
      cand_d.pal = PAL_MAXW'(obj_addr);
    end else begin
      cand_d.obj = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_q <= '0;
    end else if (cen_i) begin
      cand_q <= cand_d;
    end
  end

  assign cand_o = cand_q;

endmodule

// File: rtl/jts16_lyrmix.sv
// Two-stage tile/object priority mixer producing a palette address per pixel.
// Define JTS16_LYRMIX_HILITE_EN to add the hilite output.
module jts16_lyrmix
  import jts16_lyrmix_pkg::*;
#(
  parameter int LAYERS = 3,
  parameter int TW     = 11,
  parameter int PALW   = 11
) (
  input logic           clk,
  input logic           rst,
  jts16_lyrmix_if.slave mix_if
);

  localparam logic [LAYERS:0] OBJ_SEL   = {1'b1, {LAYERS{1'b0}}};
  localparam logic [LAYERS:0] TILE0_SEL = {{LAYERS{1'b0}}, 1'b1};

  logic [1:0]      thr_q    [LAYERS];
  logic [1:0]      thr_slot [LAYERS+1];
  logic [TW-1:0]   tile_m   [LAYERS+1];
  logic [11:0]     obj_m;
  logic [LAYERS:0] elig_en;
  cand_t           cand_q   [LAYERS+1];
  cand_t           pick_d;
  logic [LAYERS:0] sel_d;
  logic [PALW-1:0] pal_q;
  logic            shadow_q;
  logic [LAYERS:0] sel_q;
  logic            unused_pick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LAYERS; k++) thr_q[k] <= thr_default(k);
    end else if (mix_if.cfg_we && (int'(mix_if.cfg_addr) < LAYERS)) begin
      thr_q[mix_if.cfg_addr] <= mix_if.cfg_din;
    end
  end

  // Disabled layers lose their colour; the backdrop is the last layer with colour 0.
  always_comb begin
    for (int k = 0; k < LAYERS; k++) begin
      tile_m[k]   = {mix_if.tile_pxl[k*TW+3 +: TW-3],
                     mix_if.gfx_en[k] ? mix_if.tile_pxl[k*TW +: 3] : 3'd0};
      thr_slot[k] = thr_q[k];
    end
    tile_m[LAYERS]   = {1'b0, mix_if.tile_pxl[(LAYERS-1)*TW+3 +: TW-4], 3'd0};
    thr_slot[LAYERS] = 2'd0;
    obj_m   = {mix_if.obj_pxl[11:4], mix_if.gfx_en[LAYERS] ? mix_if.obj_pxl[3:0] : 4'd0};
    elig_en = {{LAYERS{1'b1}}, ~mix_if.fix_top};
  end

  for (genvar k = 0; k <= LAYERS; k++) begin : g_cand
    jts16_lyrmix_cand #(
      .TW       (TW),
      .PALW     (PALW),
      .BACKDROP (k == LAYERS)
    ) u_cand (
      .clk       (clk),
      .rst       (rst),
      .cen_i     (mix_if.pxl_cen),
      .tile_i    (tile_m[k]),
      .obj_i     (obj_m),
      .thr_i     (thr_slot[k]),
      .elig_en_i (elig_en[k]),
      .cand_o    (cand_q[k])
    );
  end

  // Scan upward from the backdrop so the topmost opaque candidate is kept last.
  always_comb begin
    pick_d = cand_q[LAYERS];
    sel_d  = cand_q[LAYERS].obj ? OBJ_SEL : '0;
    for (int k = LAYERS - 1; k >= 0; k--) begin
      sel_d  = cand_opaque(cand_q[k]) ? (cand_q[k].obj ? OBJ_SEL : (TILE0_SEL << k)) : sel_d;
      pick_d = cand_opaque(cand_q[k]) ? cand_q[k] : pick_d;
    end
  end

`ifdef JTS16_LYRMIX_HILITE_EN
  logic hilite_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hilite_q <= 1'b0;
    end else if (mix_if.pxl_cen) begin
      hilite_q <= pick_d.hilite;
    end
  end

  assign mix_if.hilite = hilite_q;
  assign unused_pick   = ^pick_d.pal[PAL_MAXW-1:PALW];
`else
  assign unused_pick   = ^{pick_d.pal[PAL_MAXW-1:PALW], pick_d.hilite};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pal_q    <= '0;
      shadow_q <= 1'b0;
      sel_q    <= '0;
    end else if (mix_if.pxl_cen) begin
      pal_q    <= pick_d.pal[PALW-1:0];
      shadow_q <= pick_d.shadow;
      sel_q    <= sel_d;
    end
  end

  assign mix_if.pal_addr = pal_q;
  assign mix_if.shadow   = shadow_q;
  assign mix_if.sel      = sel_q;

endmodule
